// File: rtl/fcpu_pkg.sv
// Shared core types: code-RAM address width and branch-predictor counter helpers.
package fcpu_pkg;

  localparam int CRAM_ADDR_W = 16;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_INIT = 2'b01;

  function automatic bp_ctr_t bp_sat_update(bp_ctr_t c, logic taken);
    bp_ctr_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Gshare direction predictor: zero-latency lookup from a flop table of 2-bit counters,
// trained by resolved branches; speculative GHR is restored from the branch snapshot on mispredict.
module branch_predictor
  import fcpu_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int GHR_W = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ce,
  input  logic                   lookup_valid,
  input  logic                   lookup_is_branch,
  input  logic [CRAM_ADDR_W-1:0] lookup_pc,
  output logic                   take_flag,
  output logic [GHR_W-1:0]       o_lookup_ghr,
  input  logic                   resolve_valid,
  input  logic [CRAM_ADDR_W-1:0] resolve_pc,
  input  logic [GHR_W-1:0]       resolve_ghr,
  input  logic                   resolve_taken,
  input  logic                   resolve_mispred
);

  localparam int DEPTH = 1 << IDX_W;

  bp_ctr_t          ctr_q [DEPTH];
  bp_ctr_t          ctr_d [DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             pred;

  // PC bits [1:0] are dropped: fetch is word-aligned.
  function automatic logic [IDX_W-1:0] bp_idx(input logic [CRAM_ADDR_W-1:0] pc,
                                               input logic [GHR_W-1:0]       g);
    return pc[IDX_W+1:2] ^ IDX_W'(g);
  endfunction

  assign lookup_idx   = bp_idx(lookup_pc, ghr_q);
  assign upd_idx      = bp_idx(resolve_pc, resolve_ghr);
  assign pred         = ctr_q[lookup_idx][1];
  assign take_flag    = nrst & pred;
  assign o_lookup_ghr = nrst ? ghr_q : '0;

  always_comb begin
    ctr_d = ctr_q;
    if (resolve_valid) begin
      ctr_d[upd_idx] = bp_sat_update(ctr_q[upd_idx], resolve_taken);
    end
  end

  // Restore wins over the speculative shift and ignores ce (halted core still retires).
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid && resolve_mispred) begin
      ghr_d = {resolve_ghr[GHR_W-2:0], resolve_taken};
    end else if (ce && lookup_valid && lookup_is_branch) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BP_CTR_INIT;
      end
      ghr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a counter-table reference model.
module tb_branch_predictor;
  import fcpu_pkg::*;

  logic                   clk;
  logic                   nrst;
  logic                   ce;
  logic                   lookup_valid;
  logic                   lookup_is_branch;
  logic [CRAM_ADDR_W-1:0] lookup_pc;
  logic                   take_flag;
  logic [3:0]             o_lookup_ghr;
  logic                   resolve_valid;
  logic [CRAM_ADDR_W-1:0] resolve_pc;
  logic [3:0]             resolve_ghr;
  logic                   resolve_taken;
  logic                   resolve_mispred;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counter values 0..3 and history as a plain integer 0..15.
  int m_ctr [64];
  int m_ghr;

  branch_predictor #(.IDX_W(6), .GHR_W(4)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .ce               (ce),
    .lookup_valid     (lookup_valid),
    .lookup_is_branch (lookup_is_branch),
    .lookup_pc        (lookup_pc),
    .take_flag        (take_flag),
    .o_lookup_ghr     (o_lookup_ghr),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .resolve_ghr      (resolve_ghr),
    .resolve_taken    (resolve_taken),
    .resolve_mispred  (resolve_mispred)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int m_idx(int pc, int g);
    return ((pc / 4) % 64) ^ g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic c, input logic lv, input logic br,
                       input int pc, input logic rv, input int rpc, input int rg,
                       input logic rt, input logic rm);
    nrst             = rst_n;
    ce               = c;
    lookup_valid     = lv;
    lookup_is_branch = br;
    lookup_pc        = CRAM_ADDR_W'(pc);
    resolve_valid    = rv;
    resolve_pc       = CRAM_ADDR_W'(rpc);
    resolve_ghr      = 4'(rg);
    resolve_taken    = rt;
    resolve_mispred  = rm;
    #1;
  endtask

  // Compare against the model for the presented cycle, then advance model and clock.
  task automatic tick(input string tag);
    int  li, ui;
    int  p;
    li = m_idx(int'(lookup_pc), m_ghr);
    p  = (m_ctr[li] >= 2) ? 1 : 0;
    if (!nrst) begin
      chk({tag, "_rst_take"}, 32'(take_flag), 0);
      chk({tag, "_rst_ghr"}, 32'(o_lookup_ghr), 0);
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_ghr = 0;
    end else begin
      if (lookup_valid) begin
        chk({tag, "_take"}, 32'(take_flag), 32'(p));
        chk({tag, "_ghr"}, 32'(o_lookup_ghr), 32'(m_ghr));
      end
      if (resolve_valid) begin
        ui = m_idx(int'(resolve_pc), int'(resolve_ghr));
        if (resolve_taken) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        else               m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      end
      if (resolve_valid && resolve_mispred)
        m_ghr = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % 16;
      else if (ce && lookup_valid && lookup_is_branch)
        m_ghr = (m_ghr * 2 + p) % 16;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("reset");
  endtask

  task automatic resolve(input int rpc, input int rg, input logic rt);
    drive(1, 1, 0, 0, 0, 1, rpc, rg, rt, 0);
    tick("resolve");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_ghr = 0;

    // Reset held two cycles, with resolves present that must be ignored.
    drive(0, 1, 1, 1, 'h10, 1, 'h10, 0, 1, 1);
    chk("rst0_take", 32'(take_flag), 0);
    chk("rst0_ghr", 32'(o_lookup_ghr), 0);
    tick("rst0");
    drive(0, 1, 1, 1, 'h10, 1, 'h10, 0, 1, 0);
    tick("rst1");

    drive(1, 1, 1, 0, 'h0, 0, 0, 0, 0, 0);
    chk("lk_pc0_take", 32'(take_flag), 0);
    chk("lk_pc0_ghr", 32'(o_lookup_ghr), 0);
    tick("lk_pc0");
    drive(1, 1, 1, 0, 'hFC, 0, 0, 0, 0, 0);
    chk("lk_pcfc_take", 32'(take_flag), 0);
    tick("lk_pcfc");

    // Training 01 -> 10 -> 11, then one not-taken back to 10.
    resolve('h10, 0, 1);
    resolve('h10, 0, 1);
    drive(1, 1, 1, 0, 'h10, 0, 0, 0, 0, 0);
    chk("train_t", 32'(take_flag), 1);
    tick("train_t");
    resolve('h10, 0, 0);
    drive(1, 1, 1, 0, 'h10, 0, 0, 0, 0, 0);
    chk("train_nt_still_t", 32'(take_flag), 1);
    tick("train_nt");

    // Saturation at strong-NT.
    do_reset();
    for (int i = 0; i < 5; i++) resolve('h20, 0, 0);
    drive(1, 1, 1, 0, 'h20, 0, 0, 0, 0, 0);
    chk("sat_nt", 32'(take_flag), 0);
    tick("sat_nt");
    resolve('h20, 0, 1);
    drive(1, 1, 1, 0, 'h20, 0, 0, 0, 0, 0);
    chk("sat_one_t", 32'(take_flag), 0);
    tick("sat_one_t");
    resolve('h20, 0, 1);
    drive(1, 1, 1, 0, 'h20, 0, 0, 0, 0, 0);
    chk("sat_two_t", 32'(take_flag), 1);
    tick("sat_two_t");

    // GHR shift: predictions 0,0,1 then a ce=0 branch lookup.
    do_reset();
    resolve('h40, 0, 1);
    resolve('h40, 0, 1);
    drive(1, 1, 1, 1, 'h0, 0, 0, 0, 0, 0);  tick("shift0");
    drive(1, 1, 1, 1, 'h4, 0, 0, 0, 0, 0);  tick("shift1");
    drive(1, 1, 1, 1, 'h40, 0, 0, 0, 0, 0);
    chk("shift2_pred", 32'(take_flag), 1);
    tick("shift2");
    drive(1, 0, 1, 1, 'h0, 0, 0, 0, 0, 0);
    chk("shift_ghr", 32'(o_lookup_ghr), 32'h1);
    tick("shift_ce0");
    drive(1, 1, 1, 0, 'h0, 0, 0, 0, 0, 0);
    chk("ce0_hold_ghr", 32'(o_lookup_ghr), 32'h1);
    tick("ce0_hold");

    // Mispredict restore, including with ce=0 and beating a same-cycle shift.
    drive(1, 0, 0, 0, 0, 1, 'h80, 'b0101, 1, 1);
    tick("restore_ce0");
    drive(1, 1, 1, 1, 'h0, 1, 'h80, 'b0110, 1, 1);
    chk("restore_ghr_1011", 32'(o_lookup_ghr), 32'hB);
    tick("restore_vs_shift");
    drive(1, 1, 1, 0, 'h0, 0, 0, 0, 0, 0);
    chk("restore_ghr_1101", 32'(o_lookup_ghr), 32'hD);
    tick("restore_after");

    // Same-index lookup and update: read sees pre-update counter.
    do_reset();
    drive(1, 1, 1, 0, 'h8, 1, 'h8, 0, 1, 0);
    chk("coll_pre", 32'(take_flag), 0);
    tick("coll");
    drive(1, 1, 1, 0, 'h8, 0, 0, 0, 0, 0);
    chk("coll_post", 32'(take_flag), 1);
    tick("coll_post");

    // Randomized traffic against the model, including ce=0 stretches and mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      logic rst_n, c, lv, br, rv, rt, rm;
      int   pc, rpc, rg;
      rst_n = ($urandom_range(0, 99) != 0);
      c     = ($urandom_range(0, 3) != 0);
      lv    = ($urandom_range(0, 3) != 0);
      br    = $urandom_range(0, 1);
      rv    = $urandom_range(0, 1);
      rt    = $urandom_range(0, 1);
      rm    = ($urandom_range(0, 3) == 0);
      pc    = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      rpc   = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) rpc = pc;
      rg    = $urandom_range(0, 15);
      drive(rst_n, c, lv, br, pc, rv, rpc, rg, rt, rm);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
